// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions: receiver state encoding, oversampling ratio and
// the sample slots used for the mid-bit majority vote. The transmitter also
// imports OVERSAMPLE so both ends agree on ticks per bit.
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int VOTE_LO    = 7;
    localparam int VOTE_HI    = 9;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// ---------------------------------------------------------------------------
// uart_baud_tick
// Free-running divider producing a one-cycle tick every BAUD_DIV clocks
// (the 16x oversample rate). 'restart' zeroes the count so the first tick
// lands a full period after a detected start edge.
// Ports:
//   clk_rx   in  receiver clock
//   rst_rx   in  synchronous active-high reset
//   restart  in  clear the divider this cycle
//   tick     out high while the divider sits at BAUD_DIV-1
// ---------------------------------------------------------------------------
module uart_baud_tick #(
    parameter int BAUD_DIV = 27
) (
    input  logic clk_rx,
    input  logic rst_rx,
    input  logic restart,
    output logic tick
);

    localparam int CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (restart || cnt_q == CNT_LAST) begin
            cnt_d = '0;
        end
    end

    assign tick = (cnt_q == CNT_LAST);

    always_ff @(posedge clk_rx) begin
        if (rst_rx) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_oversample.sv
// ---------------------------------------------------------------------------
// uart_rx_oversample
// UART receiver sampling at 16x baud with a 3-sample majority vote around
// mid-bit. Deframes start + DATA_BITS (LSB first) [+ even parity] + stop and
// holds the result until the consumer pulses read_rx.
// Optional feature macro: UART_RX_PARITY_EN (adds parity bit and
// parity_err_rx output).
// Ports:
//   clk_rx        in  receiver clock
//   rst_rx        in  synchronous active-high reset
//   data_line     in  asynchronous serial line, idle high
//   read_rx       in  one-cycle acknowledge of the held byte
//   data_rx       out held byte, valid while ready_rx=1
//   ready_rx      out byte held; level until read_rx
//   frame_err_rx  out stop bit of held byte voted 0
//   overrun_rx    out sticky: a frame completed over an unread byte
//   busy_rx       out receiver FSM not idle
//   parity_err_rx out (UART_RX_PARITY_EN only) even-parity failure
// Handshake: ready_rx is a level. A read_rx pulse while ready_rx=1 drops
// ready_rx next clock; a read_rx on the commit cycle is consumed by the old
// byte, so the new byte loads and ready_rx stays high without overrun.
// ---------------------------------------------------------------------------
module uart_rx_oversample
    import uart_pkg::*;
#(
    parameter int BAUD_DIV  = 27,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk_rx,
    input  logic                 rst_rx,
    input  logic                 data_line,
    input  logic                 read_rx,
    output logic [DATA_BITS-1:0] data_rx,
    output logic                 ready_rx,
    output logic                 frame_err_rx,
    output logic                 overrun_rx,
    output logic                 busy_rx
`ifdef UART_RX_PARITY_EN
    ,
    output logic                 parity_err_rx
`endif
);

    localparam int S_W   = $clog2(OVERSAMPLE);
    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [S_W-1:0]   S_LO    = S_W'(VOTE_LO);
    localparam logic [S_W-1:0]   S_MID   = S_W'(VOTE_LO + 1);
    localparam logic [S_W-1:0]   S_HI    = S_W'(VOTE_HI);
    localparam logic [IDX_W-1:0] IDX_END = IDX_W'(DATA_BITS - 1);

    rx_state_e            state_q, state_d;
    logic                 sync1_q, sync2_q;
    logic                 armed_q, armed_d;
    logic [S_W-1:0]       samp_q, samp_d;
    logic                 v_lo_q, v_lo_d;
    logic                 v_mid_q, v_mid_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 ready_q, ready_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;
`ifdef UART_RX_PARITY_EN
    logic                 par_bit_q, par_bit_d;
    logic                 perr_q, perr_d;
`endif

    logic rx;
    logic tick;
    logic restart;
    logic vote;
    logic at_vote;
    logic commit;

    assign rx = sync2_q;

    uart_baud_tick #(.BAUD_DIV(BAUD_DIV)) u_tick (
        .clk_rx  (clk_rx),
        .rst_rx  (rst_rx),
        .restart (restart),
        .tick    (tick)
    );

    // Third sample is taken live on the s=9 tick, so the vote resolves
    // in the same cycle it is needed.
    assign vote    = majority3(v_lo_q, v_mid_q, rx);
    assign at_vote = tick && (samp_q == S_HI);

    always_comb begin
        state_d   = state_q;
        armed_d   = armed_q;
        samp_d    = samp_q;
        v_lo_d    = v_lo_q;
        v_mid_d   = v_mid_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        restart   = 1'b0;
        commit    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_d = par_bit_q;
`endif

        if (state_q != ST_IDLE && tick) begin
            samp_d = samp_q + S_W'(1);
            if (samp_q == S_LO)  v_lo_d  = rx;
            if (samp_q == S_MID) v_mid_d = rx;
        end

        case (state_q)
            ST_IDLE: begin
                // A line stuck low (break) must go high again before the
                // next falling edge is treated as a start bit.
                if (rx) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    state_d = ST_START;
                    samp_d  = '0;
                    restart = 1'b1;
                end
            end
            ST_START: begin
                if (at_vote) begin
                    idx_d   = '0;
                    state_d = vote ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (at_vote) begin
                    shift_d = {vote, shift_q[DATA_BITS-1:1]};
                    idx_d   = idx_q + IDX_W'(1);
                    if (idx_q == IDX_END) begin
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (at_vote) begin
                    par_bit_d = vote;
                    state_d   = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (at_vote) begin
                    state_d = ST_IDLE;
                    armed_d = 1'b0;
                    commit  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output hold / read handshake.
    always_comb begin
        data_d = data_q;
        ready_d = ready_q;
        ferr_d  = ferr_q;
        ovr_d   = ovr_q;
`ifdef UART_RX_PARITY_EN
        perr_d  = perr_q;
`endif
        if (commit) begin
            data_d  = shift_q;
            ferr_d  = ~vote;
            ready_d = 1'b1;
            if (ready_q && !read_rx) begin
                ovr_d = 1'b1;
            end else if (read_rx) begin
                ovr_d = 1'b0;
            end
`ifdef UART_RX_PARITY_EN
            perr_d = ^{shift_q, par_bit_q};
`endif
        end else if (read_rx && ready_q) begin
            ready_d = 1'b0;
            ovr_d   = 1'b0;
        end
    end

    always_ff @(posedge clk_rx) begin
        if (rst_rx) begin
            state_q   <= ST_IDLE;
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            armed_q   <= 1'b0;
            samp_q    <= '0;
            v_lo_q    <= 1'b0;
            v_mid_q   <= 1'b0;
            idx_q     <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            ready_q   <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit_q <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            sync1_q   <= data_line;
            sync2_q   <= sync1_q;
            armed_q   <= armed_d;
            samp_q    <= samp_d;
            v_lo_q    <= v_lo_d;
            v_mid_q   <= v_mid_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            ready_q   <= ready_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
`ifdef UART_RX_PARITY_EN
            par_bit_q <= par_bit_d;
            perr_q    <= perr_d;
`endif
        end
    end

    assign data_rx      = data_q;
    assign ready_rx     = ready_q;
    assign frame_err_rx = ferr_q;
    assign overrun_rx   = ovr_q;
    assign busy_rx      = (state_q != ST_IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_err_rx = perr_q;
`endif

endmodule
